// File: rtl/display_scan_ctrl_if.sv
// Bundle of data/control inputs and scan outputs for the 4-digit 7-segment scanner.
// master drives display data; slave is the scan controller.
interface display_scan_ctrl_if;
  logic [15:0] value;
  logic [3:0]  dig_en;
  logic [3:0]  dp_en;
  logic        lzb;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_done;

  modport master (
    output value, dig_en, dp_en, lzb,
    input  seg, an, dp, digit_sel, frame_done
  );

  modport slave (
    input  value, dig_en, dp_en, lzb,
    output seg, an, dp, digit_sel, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller with per-slot blanking,
// frame-synchronous shadowing of display data and leading-zero suppression.
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1
) (
  input  logic                clkin,
  input  logic                greset,
  display_scan_ctrl_if.slave  bus
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PrescMax = PW'(SCAN_DIV - 1);

  typedef enum logic {StBlank, StDrive} scan_st_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    dsel_q, dsel_d;
  logic [15:0]   vshadow_q, vshadow_d;
  logic [3:0]    dpsh_q, dpsh_d;
  logic          fd_q, fd_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [1:0]    digit_sel_q;

  scan_st_e      scan_st;
  logic [3:0]    lz_sup;
  logic          suppress;
  logic [3:0]    nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'b1111111;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Prescaler, slot index and frame-boundary shadow load.
  always_comb begin
    presc_d   = presc_q;
    dsel_d    = dsel_q;
    vshadow_d = vshadow_q;
    dpsh_d    = dpsh_q;
    fd_d      = 1'b0;
    if (presc_q == PrescMax) begin
      presc_d = '0;
      dsel_d  = dsel_q + 2'd1;
      if (dsel_q == 2'd3) begin
        vshadow_d = bus.value;
        dpsh_d    = bus.dp_en;
        fd_d      = 1'b1;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Scan state and digit suppression; digit 0 is never blanked as a leading zero.
  always_comb begin
    scan_st   = (32'(presc_q) < BLANK_CYC) ? StBlank : StDrive;
    lz_sup[3] = (vshadow_q[15:12] == 4'h0);
    lz_sup[2] = lz_sup[3] && (vshadow_q[11:8] == 4'h0);
    lz_sup[1] = lz_sup[2] && (vshadow_q[7:4] == 4'h0);
    lz_sup[0] = 1'b0;
    suppress  = !bus.dig_en[dsel_q] || (bus.lzb && lz_sup[dsel_q]);
    nib       = vshadow_q[{dsel_q, 2'b00} +: 4];
  end

  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (scan_st == StDrive && !suppress) begin
      an_d  = ~(4'b0001 << dsel_q);
      seg_d = hex7(nib);
      dp_d  = ~dpsh_q[dsel_q];
    end
  end

  always_ff @(posedge clkin or posedge greset) begin
    if (greset) begin
      presc_q     <= '0;
      dsel_q      <= 2'd0;
      vshadow_q   <= 16'h0000;
      dpsh_q      <= 4'h0;
      fd_q        <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
      dp_q        <= 1'b1;
      digit_sel_q <= 2'd0;
    end else begin
      presc_q     <= presc_d;
      dsel_q      <= dsel_d;
      vshadow_q   <= vshadow_d;
      dpsh_q      <= dpsh_d;
      fd_q        <= fd_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      digit_sel_q <= dsel_q;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.dp         = dp_q;
  assign bus.digit_sel  = digit_sel_q;
  assign bus.frame_done = fd_q;

endmodule
